// File: rtl/logger_capture_buf_if.sv
// Record handshake bundle between the capture buffer and the logger monitor.
// master drives head record and valid; slave returns ready.
interface logger_capture_buf_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int TS_W   = 16
);
    logic                     rec_valid;
    logic                     rec_ready;
    logic [NUM_CH*DATA_W-1:0] rec_data;
    logic [NUM_CH-1:0]        rec_mask;
    logic [TS_W-1:0]          rec_ts;

    modport master (
        output rec_valid,
        output rec_data,
        output rec_mask,
        output rec_ts,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        input  rec_mask,
        input  rec_ts,
        output rec_ready
    );
endinterface

// File: rtl/logger_capture_buf.sv
// Multi-channel sampler with timestamps feeding a first-word-fall-through FIFO.
// Captures every cycle or on channel change; drops and counts records when full.
module logger_capture_buf #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       mode,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    logger_capture_buf_if.master       rec,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = NUM_CH * DATA_W;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [TS_W-1:0]    r_ts;
    logic [SW-1:0]      r_prev;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic [15:0]        r_ovf;

    logic [SW-1:0]      r_mem_data [DEPTH];
    logic [NUM_CH-1:0]  r_mem_mask [DEPTH];
    logic [TS_W-1:0]    r_mem_ts   [DEPTH];

    logic [NUM_CH-1:0]  w_mask;
    logic [NUM_CH-1:0]  w_cap_mask;
    logic               w_cap;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mask[i] = ch_data[i*DATA_W +: DATA_W] != r_prev[i*DATA_W +: DATA_W];
        end
    end

    // ARM always records, with every channel flagged as changed
    assign w_cap = enable &&
                   ((r_state == ARM) ||
                    ((r_state == RUN) && (!mode || (|w_mask))));
    assign w_cap_mask = (r_state == ARM) ? '1 : w_mask;

    assign w_full  = (r_level == FULL_LVL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && rec.rec_ready;
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ts     <= '0;
            r_prev   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (enable) r_state <= ARM;
                ARM:  r_state <= enable ? RUN : IDLE;
                RUN:  if (!enable) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (r_state != IDLE) begin
                r_ts   <= r_ts + 1'b1;
                r_prev <= ch_data;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
        end
    end

    // Storage needs no reset: level gates visibility of stale entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= ch_data;
            r_mem_mask[r_wr_ptr] <= w_cap_mask;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    assign rec.rec_valid = w_valid;
    assign rec.rec_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign rec.rec_mask  = w_valid ? r_mem_mask[r_rd_ptr] : '0;
    assign rec.rec_ts    = w_valid ? r_mem_ts[r_rd_ptr]   : '0;
    assign level         = r_level;
    assign overflow_cnt  = r_ovf;
endmodule

// File: tb/tb_logger_capture_buf.sv
// Directed bench for logger_capture_buf: vector table plus full/reset/wrap sequences.
// A second instance with a 4-bit timestamp exercises counter wrap.
module tb_logger_capture_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, mode;
    logic [31:0] ch_data;
    logic [4:0]  level;
    logic [15:0] overflow_cnt;

    logic        enable2;
    logic [4:0]  level2;
    logic [15:0] overflow_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logger_capture_buf_if #(.NUM_CH(4), .DATA_W(8), .TS_W(16)) bus ();
    logger_capture_buf_if #(.NUM_CH(4), .DATA_W(8), .TS_W(4))  bus2 ();

    logger_capture_buf #(.NUM_CH(4), .DATA_W(8), .DEPTH(16), .TS_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .ch_data(ch_data), .rec(bus.master),
        .level(level), .overflow_cnt(overflow_cnt)
    );

    logger_capture_buf #(.NUM_CH(4), .DATA_W(8), .DEPTH(16), .TS_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .mode(1'b0),
        .ch_data(ch_data), .rec(bus2.master),
        .level(level2), .overflow_cnt(overflow_cnt2)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        mode;
        logic [31:0] data;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        logic [15:0] e_ts;
        logic [4:0]  e_lvl;
        logic [15:0] e_ovf;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic e, logic m, logic [31:0] d, logic rd,
                                logic ev, logic [31:0] ed, logic [3:0] em,
                                logic [15:0] et, logic [4:0] el);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.data = d; v.rdy = rd;
        v.e_valid = ev; v.e_data = ed; v.e_mask = em;
        v.e_ts = et; v.e_lvl = el; v.e_ovf = 16'd0;
        return v;
    endfunction

    localparam logic [31:0] D1 = 32'h0A0B0C0D;
    localparam logic [31:0] D2 = 32'h0A0B550D;

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; ch_data = '0;
        bus.rec_ready = 1'b1; bus2.rec_ready = 1'b1; enable2 = 1'b0;

        // every-cycle mode, then on-change mode with a late mode switch
        tv[0]  = mk(0, 0, 0, 0,  1, 0, 0,  4'h0, 0, 0);
        tv[1]  = mk(1, 1, 0, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[2]  = mk(1, 1, 0, D1, 1, 1, D1, 4'hF, 0, 1);
        tv[3]  = mk(1, 1, 0, D1, 1, 1, D1, 4'h0, 1, 1);
        tv[4]  = mk(1, 1, 0, D1, 1, 1, D1, 4'h0, 2, 1);
        tv[5]  = mk(1, 0, 0, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[6]  = mk(0, 0, 0, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[7]  = mk(1, 1, 1, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[8]  = mk(1, 1, 1, D1, 1, 1, D1, 4'hF, 0, 1);
        tv[9]  = mk(1, 1, 1, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[10] = mk(1, 1, 1, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[11] = mk(1, 1, 1, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[12] = mk(1, 1, 1, D1, 1, 0, 0,  4'h0, 0, 0);
        tv[13] = mk(1, 1, 1, D2, 1, 1, D2, 4'h2, 5, 1);
        tv[14] = mk(1, 1, 0, D2, 1, 1, D2, 4'h0, 6, 1);
        tv[15] = mk(1, 0, 0, D2, 1, 0, 0,  4'h0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            rst_n = tv[i].rst_n; enable = tv[i].en; mode = tv[i].mode;
            ch_data = tv[i].data; bus.rec_ready = tv[i].rdy;
            step();
            chk($sformatf("v%0d valid", i), 32'(bus.rec_valid), 32'(tv[i].e_valid));
            chk($sformatf("v%0d level", i), 32'(level), 32'(tv[i].e_lvl));
            chk($sformatf("v%0d ovf", i), 32'(overflow_cnt), 32'(tv[i].e_ovf));
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d data", i), bus.rec_data, tv[i].e_data);
                chk($sformatf("v%0d mask", i), 32'(bus.rec_mask), 32'(tv[i].e_mask));
                chk($sformatf("v%0d ts", i), 32'(bus.rec_ts), 32'(tv[i].e_ts));
            end
        end

        // fill with consumer stalled: 20 captures into 16 slots
        rst_n = 1'b0; enable = 1'b0; step();
        rst_n = 1'b1; mode = 1'b0; ch_data = D1; bus.rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 21; i++) step();
        chk("full level", 32'(level), 32'd16);
        chk("full ovf", 32'(overflow_cnt), 32'd4);
        chk("full head ts", 32'(bus.rec_ts), 32'd0);
        chk("full head mask", 32'(bus.rec_mask), 32'hF);
        step();
        chk("stall ovf", 32'(overflow_cnt), 32'd5);
        chk("stall head ts", 32'(bus.rec_ts), 32'd0);
        chk("stall head data", bus.rec_data, D1);

        // full plus pop in the same cycle: write accepted
        bus.rec_ready = 1'b1; step();
        chk("pop+push level", 32'(level), 32'd16);
        chk("pop+push ovf", 32'(overflow_cnt), 32'd5);
        chk("pop+push head ts", 32'(bus.rec_ts), 32'd1);
        chk("pop+push head mask", 32'(bus.rec_mask), 32'h0);

        enable = 1'b0; bus.rec_ready = 1'b0; step();
        chk("disable level", 32'(level), 32'd16);
        chk("disable head ts", 32'(bus.rec_ts), 32'd1);

        // drain 8, then reset with records still queued
        bus.rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("drain level", 32'(level), 32'd8);
        chk("drain head ts", 32'(bus.rec_ts), 32'd9);
        bus.rec_ready = 1'b0; rst_n = 1'b0; step();
        chk("rst valid", 32'(bus.rec_valid), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst ovf", 32'(overflow_cnt), 32'd0);
        chk("rst data", bus.rec_data, 32'd0);
        chk("rst ts", 32'(bus.rec_ts), 32'd0);
        rst_n = 1'b1; step();
        chk("post rst level", 32'(level), 32'd0);

        // 4-bit timestamp wrap on the second instance
        enable2 = 1'b1; ch_data = 32'h11223344; step();
        chk("wrap arm valid", 32'(bus2.rec_valid), 32'd0);
        for (int i = 0; i < 18; i++) begin
            step();
            chk($sformatf("wrap valid %0d", i), 32'(bus2.rec_valid), 32'd1);
            chk($sformatf("wrap ts %0d", i), 32'(bus2.rec_ts), 32'(i % 16));
        end
        enable2 = 1'b0; step();
        chk("wrap drained", 32'(level2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
